bn_sequencer: RTL
=================

BN_SEQUENCER -- requirements
Module: bn_sequencer

Interface
REQ-001 SHALL have parameter Data_Width, default 32, element width of coefficients and row elements.
REQ-002 SHALL have parameter N, default 32, channels per row and coefficient pairs per layer.
REQ-003 SHALL have parameter CNT_W, default 16, width of the row counters.
REQ-004 CLK  input  1  clock, all state on posedge.
REQ-005 RST  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle request to begin a layer; honoured only in IDLE.
REQ-007 num_rows  input  CNT_W  rows in the layer; sampled on accepted start.
REQ-008 param_rd_en  output  1  coefficient memory read strobe.
REQ-009 param_addr  output  $clog2(N)  channel index being read.
REQ-010 param_rdata  input  2*Data_Width  {A,B} for the addressed channel, valid exactly 1 cycle after param_rd_en.
REQ-011 in_valid / in_ready / in_row  input / output / input  1 / 1 / N*Data_Width  upstream row handshake.
REQ-012 bn_in_row / bn_in_valid  output  N*Data_Width / 1  drive to the batch-norm datapath.
REQ-013 coef_a, coef_b  output  Data_Width x [0:N-1]  per-channel scale and offset to the datapath.
REQ-014 bn_out_valid  input  1  datapath result strobe, 1 cycle after bn_in_valid.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse on layer completion.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, STREAM, DRAIN, DONE.
REQ-018 IDLE -> LOAD on start; num_rows latched; start while busy SHALL be ignored.
REQ-019 LOAD: param_rd_en=1 with param_addr 0..N-1 on N consecutive cycles; the data returned one cycle later SHALL be written into coef_a/coef_b at the delayed address.
REQ-020 LOAD -> STREAM the cycle after the last read data is captured (N+1 cycles in LOAD); if num_rows==0, LOAD -> DONE instead.
REQ-021 coef_a/coef_b SHALL be stable throughout STREAM and DRAIN and retain values after DONE.
REQ-022 STREAM: in_ready = 1 while issued < num_rows; a transfer occurs when in_valid && in_ready.
REQ-023 On a transfer, bn_in_row = in_row and bn_in_valid = 1 combinationally in the same cycle; issued increments. Otherwise bn_in_valid = 0.
REQ-024 Each bn_out_valid SHALL increment completed; bn_out_valid outside STREAM/DRAIN SHALL be ignored.
REQ-025 STREAM -> DRAIN when the transfer making issued == num_rows occurs.
REQ-026 DRAIN -> DONE when completed == num_rows (including the increment from the current cycle).
REQ-027 DONE asserts done for exactly one cycle, then -> IDLE; in_ready = 0 outside STREAM.
REQ-028 Counters SHALL be CNT_W bits, cleared on entry to LOAD; no wrap-around, as num_rows <= 2^CNT_W-1.

Reset
REQ-029 On RST low: state IDLE, counters 0, coef_a/coef_b 0, param_rd_en 0, param_addr 0, in_ready 0, bn_in_valid 0, busy 0, done 0.
REQ-030 Reset asserted mid-layer SHALL abort immediately to the reset state, with no done pulse.

Structure
REQ-031 Package bn_pkg SHALL hold the FSM state enum and the default Data_Width/N/CNT_W constants.
REQ-032 No sub-module is required; the datapath is instantiated by the parent, not inside this block.

Verification
REQ-033 N=4, num_rows=3, rdata={A=i+1,B=10*i}, in_valid always 1: coefficients match after 5 LOAD cycles, 3 transfers in 3 consecutive cycles, done 1 cycle after the third bn_out_valid.
REQ-034 num_rows=0: 4 reads then done pulse; in_ready and bn_in_valid never high.
REQ-035 in_valid toggling 1,0,0,1,1 with num_rows=3: issued reaches 3 exactly on the matching cycles, and bn_in_valid mirrors the transfers.
REQ-036 start pulsed during STREAM: no effect, and num_rows is not re-latched.
REQ-037 RST low during STREAM after 1 row: all outputs return to reset values and no done pulse; a subsequent start runs a full layer.
REQ-038 Two back-to-back layers with different coefficients: second-layer coef outputs change only during its LOAD.

Source files
------------

// File: rtl/bn_pkg.sv
// bn_pkg: shared FSM state type and default sizing for the batch-norm sequencer
package bn_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int N_DEF = 32;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} state_t;
endpackage

// File: rtl/bn_sequencer.sv
// bn_sequencer: loads per-channel BN coefficients, then streams rows to the datapath and waits for results
module bn_sequencer
  import bn_pkg::*;
#(
  parameter int Data_Width = DATA_WIDTH_DEF,
  parameter int N = N_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      start,
  input  logic [CNT_W-1:0]          num_rows,
  output logic                      param_rd_en,
  output logic [$clog2(N)-1:0]      param_addr,
  input  logic [2*Data_Width-1:0]   param_rdata,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N*Data_Width-1:0]   in_row,
  output logic [N*Data_Width-1:0]   bn_in_row,
  output logic                      bn_in_valid,
  output logic [Data_Width-1:0]     coef_a [0:N-1],
  output logic [Data_Width-1:0]     coef_b [0:N-1],
  input  logic                      bn_out_valid,
  output logic                      busy,
  output logic                      done
);
  localparam int AW = $clog2(N);
  localparam int LW = $clog2(N + 1);
  state_t state, state_nxt;
  logic [LW-1:0] load_cnt;
  logic [CNT_W-1:0] rows, issued, completed, comp_nxt;
  logic rd_d, xfer, bov;
  logic [AW-1:0] addr_d;
  // Decode handshakes and strobes from the current state and counters
  always_comb begin
    param_rd_en = state == LOAD && load_cnt < LW'(N);
    param_addr = load_cnt[AW-1:0];
    in_ready = state == STREAM && issued < rows;
    xfer = in_valid && in_ready;
    bn_in_valid = xfer;
    bn_in_row = in_row;
    bov = bn_out_valid && (state == STREAM || state == DRAIN);
    comp_nxt = completed + CNT_W'(bov);
    busy = state != IDLE;
    done = state == DONE;
  end
  // Next-state logic; LOAD lasts N reads plus one cycle for the last returned word
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (load_cnt == LW'(N)) state_nxt = rows == '0 ? DONE : STREAM;
      STREAM:  if (xfer && issued + CNT_W'(1) == rows) state_nxt = DRAIN;
      DRAIN:   if (comp_nxt == rows) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // State register
  always_ff @(posedge CLK or negedge RST)
    if (!RST) state <= IDLE;
    else state <= state_nxt;
  // Row counters, load counter and the one-cycle-delayed read tracking
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      rows <= '0;
      issued <= '0;
      completed <= '0;
      load_cnt <= '0;
      rd_d <= 1'b0;
      addr_d <= '0;
    end else begin
      rd_d <= param_rd_en;
      addr_d <= param_addr;
      if (state == IDLE && start) begin
        rows <= num_rows;
        issued <= '0;
        completed <= '0;
        load_cnt <= '0;
      end else begin
        if (state == LOAD) load_cnt <= load_cnt + LW'(1);
        if (xfer) issued <= issued + CNT_W'(1);
        completed <= comp_nxt;
      end
    end
  // Coefficient bank: written only when read data returns, so it holds through STREAM/DRAIN/IDLE
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      for (int i = 0; i < N; i++) begin
        coef_a[i] <= '0;
        coef_b[i] <= '0;
      end
    end else if (rd_d) begin
      coef_a[addr_d] <= param_rdata[2*Data_Width-1:Data_Width];
      coef_b[addr_d] <= param_rdata[Data_Width-1:0];
    end
endmodule
